micro_sequencer: RTL and testbench

//  Producer end of the 16-bit microinstruction interface: generates one uinstr per clock for
//  the control decoder. Owns the T-state counter, emits the fixed fetch words at T0/T1, reads
//  T2..T7 from the microcode ROM at {opcode,tstate}, and honours RT, stall and single-step.

---
 rtl/micro_sequencer.sv | 83 ++++++++
 tb/tb_micro_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microinstruction sequencer: owns the T-state counter, issues the fixed fetch words at T0/T1,
// forwards microcode ROM words for T2..T7, and gates issue on stall / single-step.
module micro_sequencer #(
  parameter int unsigned OPW    = 8,
  parameter logic [15:0] FETCH0 = 16'h8040,
  parameter logic [15:0] FETCH1 = 16'hB480,
  parameter logic [15:0] NOP    = 16'h8000
) (
  input  logic           clk_i,
  input  logic           reset_bar_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic [15:0]    rom_data_i,
  input  logic           stall_i,
  input  logic           single_step_i,
  input  logic           step_i,
  output logic [15:0]    uinstr_o,
  output logic [OPW+2:0] rom_addr_o,
  output logic [2:0]     tstate_o,
  output logic           instr_done_o
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e      state_q, state_d;
  logic [2:0]  tstate_q, tstate_d;
  logic        step_q;

  logic        step_edge;
  logic        advance;
  logic [15:0] word;
  logic        rt;
  logic        last;

  // State register: FSM state, T-state counter and step history.
  always_ff @(posedge clk_i or negedge reset_bar_i) begin
    if (!reset_bar_i) begin
      state_q  <= StBoot;
      tstate_q <= 3'd0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
      step_q   <= step_i;
    end
  end

  // Issue qualification and word selection for the current T-state.
  always_comb begin
    step_edge = step_i & ~step_q;
    advance   = (state_q == StRun) & ~stall_i & (~single_step_i | step_edge);
    unique case (tstate_q)
      3'd0:    word = FETCH0;
      3'd1:    word = FETCH1;
      default: word = rom_data_i;
    endcase
    // RT is only meaningful in ROM words; fetch words never carry it.
    rt   = (tstate_q > 3'd1) & word[15] & word[11];
    last = rt | (tstate_q == 3'd7);
  end

  // Next-state: BOOT lasts one clock; T-state moves only on an issued word.
  always_comb begin
    state_d  = state_q;
    tstate_d = tstate_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
    if (advance) begin
      tstate_d = last ? 3'd0 : tstate_q + 3'd1;
    end
  end

  // Outputs: a held cycle issues NOP so side effects are never repeated.
  always_comb begin
    uinstr_o     = advance ? word : NOP;
    instr_done_o = advance & last;
    rom_addr_o   = {opcode_i, tstate_q};
    tstate_o     = tstate_q;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

  localparam logic [15:0] F0 = 16'h8040;
  localparam logic [15:0] F1 = 16'hB480;
  localparam logic [15:0] NP = 16'h8000;

  logic        clk = 1'b0;
  logic        reset_bar = 1'b0;
  logic [7:0]  opcode = 8'h12;
  logic [15:0] rom_data;
  logic        stall = 1'b0;
  logic        single_step = 1'b0;
  logic        step = 1'b0;
  logic [15:0] uinstr;
  logic [10:0] rom_addr;
  logic [2:0]  tstate;
  logic        instr_done;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic        m_run = 1'b0;
  int          m_t = 0;
  logic        m_stepq = 1'b0;
  logic [15:0] rom_mem [0:2047];

  always #5 clk = ~clk;

  // ROM is addressed from the model's own notion of T-state.
  assign rom_data = rom_mem[{opcode, m_t[2:0]}];

  micro_sequencer #(.OPW(8)) dut (
    .clk_i         (clk),
    .reset_bar_i   (reset_bar),
    .opcode_i      (opcode),
    .rom_data_i    (rom_data),
    .stall_i       (stall),
    .single_step_i (single_step),
    .step_i        (step),
    .uinstr_o      (uinstr),
    .rom_addr_o    (rom_addr),
    .tstate_o      (tstate),
    .instr_done_o  (instr_done)
  );

  function automatic logic m_issue();
    return m_run && !stall && (!single_step || (step && !m_stepq));
  endfunction

  function automatic logic [15:0] m_word();
    if (m_t == 0) return F0;
    if (m_t == 1) return F1;
    return rom_data;
  endfunction

  function automatic logic m_ends();
    logic [15:0] w;
    w = m_word();
    return (m_t >= 2 && w[15] && w[11]) || m_t == 7;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update: one issued word moves the instruction forward one T-state.
  always @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      m_run   <= 1'b0;
      m_t     <= 0;
      m_stepq <= 1'b0;
    end else begin
      if (m_issue()) m_t <= m_ends() ? 0 : m_t + 1;
      m_run   <= 1'b1;
      m_stepq <= step;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("cmp_uinstr", {16'd0, uinstr}, {16'd0, m_issue() ? m_word() : NP});
    chk("cmp_done", {31'd0, instr_done}, {31'd0, m_issue() && m_ends()});
    chk("cmp_tstate", {29'd0, tstate}, m_t);
    chk("cmp_rom_addr", {21'd0, rom_addr}, {21'd0, opcode, m_t[2:0]});
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = 16'h0000;

    // Reset state
    tick();
    tick();
    chk("rst_tstate", {29'd0, tstate}, 32'd0);
    chk("rst_uinstr", {16'd0, uinstr}, 32'h8000);
    chk("rst_done", {31'd0, instr_done}, 32'd0);
    chk("rst_rom_addr", {21'd0, rom_addr}, 32'h090);
    reset_bar = 1'b1;
    #1;
    chk("boot_uinstr", {16'd0, uinstr}, 32'h8000);

    // Free run through a full 8-state instruction
    for (int i = 0; i < 9; i++) begin
      logic [15:0] e;
      tick();
      e = (i == 0 || i == 8) ? 16'h8040 : (i == 1) ? 16'hB480 : 16'h0000;
      chk("run_uinstr", {16'd0, uinstr}, {16'd0, e});
      chk("run_tstate", {29'd0, tstate}, i % 8);
      chk("run_done", {31'd0, instr_done}, (i == 7) ? 32'd1 : 32'd0);
    end

    // RT word at T2 ends the instruction early
    rom_mem[{8'h12, 3'd2}] = 16'h8800;
    tick();
    tick();
    chk("rt_uinstr", {16'd0, uinstr}, 32'h8800);
    chk("rt_done", {31'd0, instr_done}, 32'd1);
    tick();
    chk("rt_next_tstate", {29'd0, tstate}, 32'd0);
    chk("rt_next_uinstr", {16'd0, uinstr}, 32'h8040);
    rom_mem[{8'h12, 3'd2}] = 16'h0000;

    // Stall for three cycles at T1
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      #0;
      chk("stall_uinstr", {16'd0, uinstr}, 32'h8000);
      chk("stall_tstate", {29'd0, tstate}, 32'd1);
    end
    tick();
    stall = 1'b0;
    #1;
    chk("unstall_uinstr", {16'd0, uinstr}, 32'hB480);
    tick();
    chk("after_stall_tstate", {29'd0, tstate}, 32'd2);
    chk("after_stall_uinstr", {16'd0, uinstr}, 32'h0000);

    // Single-step: level-held step gives one advance, pulses give one each
    for (int i = 0; i < 6; i++) tick();
    chk("ss_start_tstate", {29'd0, tstate}, 32'd0);
    single_step = 1'b1;
    step = 1'b1;
    #1;
    chk("ss_edge_uinstr", {16'd0, uinstr}, 32'h8040);
    tick();
    chk("ss_held_uinstr", {16'd0, uinstr}, 32'h8000);
    for (int i = 0; i < 3; i++) tick();
    chk("ss_held_tstate", {29'd0, tstate}, 32'd1);
    step = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
    end
    chk("ss_pulses_tstate", {29'd0, tstate}, 32'd4);

    // Asynchronous reset between edges at T4
    single_step = 1'b0;
    #2;
    reset_bar = 1'b0;
    #1;
    chk("areset_tstate", {29'd0, tstate}, 32'd0);
    chk("areset_uinstr", {16'd0, uinstr}, 32'h8000);
    tick();
    reset_bar = 1'b1;
    #1;
    chk("areset_boot", {16'd0, uinstr}, 32'h8000);
    tick();
    chk("areset_f0", {16'd0, uinstr}, 32'h8040);
    tick();
    chk("areset_f1", {16'd0, uinstr}, 32'hB480);

    // ROM address composition
    tick();
    tick();
    opcode = 8'h5A;
    #1;
    chk("addr_tstate", {29'd0, tstate}, 32'd3);
    chk("addr_value", {21'd0, rom_addr}, 32'h2D3);

    // Randomized traffic
    for (int i = 0; i < 2048; i++) rom_mem[i] = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset_bar = ($urandom_range(0, 199) != 0);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) single_step = ~single_step;
      step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) opcode = 8'($urandom);
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
